// File: rtl/graph_pkg.sv
// graph_pkg: shared types and default widths for the graph controller slice.
//   state_t - sequencer states of graph_controller
//   upd_t   - one queued edge update {src, dst, weight} at default widths
//   DEF_*   - default parameter values used by the interface and the top
package graph_pkg;

  localparam int DEF_VERT_W         = 6;
  localparam int DEF_WEIGHT_W       = 32;
  localparam int DEF_DIST_W         = 32;
  localparam int DEF_NUM_PHASES     = 3;
  localparam int DEF_FIFO_DEPTH     = 4;
  localparam int DEF_TIMEOUT_CYCLES = 65535;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UPD_FWD,
    ST_UPD_REV,
    ST_LAUNCH,
    ST_RUN,
    ST_GAP,
    ST_FIN
  } state_t;

  typedef struct packed {
    logic [DEF_VERT_W-1:0]   src;
    logic [DEF_VERT_W-1:0]   dst;
    logic [DEF_WEIGHT_W-1:0] weight;
  } upd_t;

endpackage

// File: rtl/graph_controller_if.sv
// graph_controller_if: host edge-update handshake.
//   valid/ready      - update handshake, transfer when both are high
//   src, dst, weight - edge endpoints and forward weight
// master modport: host side; slave modport: graph_controller side.
interface graph_controller_if
  import graph_pkg::*;
#(
  parameter int VERT_W   = DEF_VERT_W,
  parameter int WEIGHT_W = DEF_WEIGHT_W
);
  logic                valid;
  logic                ready;
  logic [VERT_W-1:0]   src;
  logic [VERT_W-1:0]   dst;
  logic [WEIGHT_W-1:0] weight;

  modport master (output valid, src, dst, weight, input ready);
  modport slave  (input valid, src, dst, weight, output ready);
endinterface

// File: rtl/graph_upd_fifo.sv
// graph_upd_fifo: synchronous update queue.
//   clk, rst     - clock, asynchronous active-high reset
//   push, din    - write request (ignored when full) and data
//   pop, dout    - read request (ignored when empty) and head entry
//   full, empty  - registered occupancy flags
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module graph_upd_fifo #(
  parameter int DATA_W = 44,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_LAST = (PTR_W+1)'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // NOTE: storage has no reset; only pointers and flags decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10: begin
          count <= count + 1'b1;
          full  <= (count == CNT_LAST);
          empty <= 1'b0;
        end
        2'b01: begin
          count <= count - 1'b1;
          full  <= 1'b0;
          empty <= (count == (PTR_W+1)'(1));
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/graph_controller.sv
// graph_controller: update queue, adjacency writer and engine-chain sequencer.
//   clk, graph_reset      - clock, asynchronous active-high reset
//   upd                   - host edge-update handshake (slave modport)
//   run_req               - request one run of the engine chain (merged)
//   busy, run_done        - activity flag, one-cycle completion pulse
//   err_timeout           - sticky per-phase watchdog error
//   ph_start / ph_done    - one-hot engine start, per-engine done
//   ph_*                  - flattened per-engine memory requests (slice k used)
//   vm_* / am_*           - vertex / adjacency memory ports
// Build option: GRAPH_CTRL_WATCHDOG_EN enables the per-phase watchdog;
// without it err_timeout is tied low and RUN waits for ph_done forever.
module graph_controller
  import graph_pkg::*;
#(
  parameter int VERT_W         = DEF_VERT_W,
  parameter int WEIGHT_W       = DEF_WEIGHT_W,
  parameter int DIST_W         = DEF_DIST_W,
  parameter int NUM_PHASES     = DEF_NUM_PHASES,
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                         clk,
  input  logic                         graph_reset,
  graph_controller_if.slave            upd,
  input  logic                         run_req,
  output logic                         busy,
  output logic                         run_done,
  output logic                         err_timeout,
  output logic [NUM_PHASES-1:0]        ph_start,
  input  logic [NUM_PHASES-1:0]        ph_done,
  input  logic [NUM_PHASES*VERT_W-1:0] ph_vaddr_a,
  input  logic [NUM_PHASES*VERT_W-1:0] ph_vaddr_b,
  input  logic [NUM_PHASES*VERT_W-1:0] ph_arow,
  input  logic [NUM_PHASES*VERT_W-1:0] ph_acol,
  input  logic [NUM_PHASES*DIST_W-1:0] ph_vdata_b,
  input  logic [NUM_PHASES-1:0]        ph_vwe_b,
  output logic [VERT_W-1:0]            vm_addr_a,
  output logic [VERT_W-1:0]            vm_addr_b,
  output logic [DIST_W-1:0]            vm_data_b,
  output logic                         vm_we_b,
  output logic [VERT_W-1:0]            am_row,
  output logic [VERT_W-1:0]            am_col,
  output logic [WEIGHT_W-1:0]          am_data,
  output logic                         am_we
);
  localparam int K_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
  localparam logic [K_W-1:0] LAST_K = K_W'(NUM_PHASES - 1);

  typedef struct packed {
    logic [VERT_W-1:0]   src;
    logic [VERT_W-1:0]   dst;
    logic [WEIGHT_W-1:0] weight;
  } entry_t;

  state_t         state;
  state_t         state_next;
  logic [K_W-1:0] k;
  logic           run_pending;
  entry_t         cur;
  entry_t         q_dout;
  logic           q_full;
  logic           q_empty;
  logic           q_pop;
  logic           launch;
  logic           timeout;

  graph_upd_fifo #(
    .DATA_W ($bits(entry_t)),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (graph_reset),
    .push  (upd.valid),
    .din   ({upd.src, upd.dst, upd.weight}),
    .pop   (q_pop),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty)
  );

  assign upd.ready = !q_full;
  assign busy      = (state != ST_IDLE) || !q_empty;

`ifdef GRAPH_CTRL_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt;
  logic            err_q;

  // Fires on the TIMEOUT_CYCLES-th RUN cycle unless the engine finishes then.
  assign timeout     = (state == ST_RUN) && !ph_done[k] && (wd_cnt == WD_LAST);
  assign err_timeout = err_q;

  always_ff @(posedge clk or posedge graph_reset) begin
    if (graph_reset) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == ST_LAUNCH)   wd_cnt <= '0;
      else if (state == ST_RUN) wd_cnt <= wd_cnt + 1'b1;
      if (launch)               err_q  <= 1'b0;
      else if (timeout)         err_q  <= 1'b1;
    end
  end
`else
  assign timeout     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    q_pop      = 1'b0;
    launch     = 1'b0;
    run_done   = 1'b0;
    ph_start   = '0;
    vm_addr_a  = '0;
    vm_addr_b  = '0;
    vm_data_b  = '0;
    vm_we_b    = 1'b0;
    am_row     = '0;
    am_col     = '0;
    am_data    = '0;
    am_we      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // Pending updates always drain before a run is launched.
        if (!q_empty) begin
          q_pop      = 1'b1;
          state_next = ST_UPD_FWD;
        end else if (run_pending) begin
          launch     = 1'b1;
          state_next = ST_LAUNCH;
        end
      end
      ST_UPD_FWD: begin
        am_we      = 1'b1;
        am_row     = cur.src;
        am_col     = cur.dst;
        am_data    = cur.weight;
        state_next = (cur.src == cur.dst) ? ST_IDLE : ST_UPD_REV;
      end
      ST_UPD_REV: begin
        am_we      = 1'b1;
        am_row     = cur.dst;
        am_col     = cur.src;
        am_data    = '0 - cur.weight;  // wraps, so the most negative weight maps to itself
        state_next = ST_IDLE;
      end
      ST_LAUNCH: begin
        ph_start[k] = 1'b1;
        state_next  = ST_RUN;
      end
      ST_RUN: begin
        vm_addr_a = ph_vaddr_a[k*VERT_W +: VERT_W];
        vm_addr_b = ph_vaddr_b[k*VERT_W +: VERT_W];
        vm_data_b = ph_vdata_b[k*DIST_W +: DIST_W];
        vm_we_b   = ph_vwe_b[k];
        am_row    = ph_arow[k*VERT_W +: VERT_W];
        am_col    = ph_acol[k*VERT_W +: VERT_W];
        if (ph_done[k])   state_next = ST_GAP;
        else if (timeout) state_next = ST_IDLE;
      end
      ST_GAP:  state_next = (k == LAST_K) ? ST_FIN : ST_LAUNCH;
      ST_FIN: begin
        run_done   = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge graph_reset) begin
    if (graph_reset) begin
      state       <= ST_IDLE;
      k           <= '0;
      run_pending <= 1'b0;
      cur         <= '0;
    end else begin
      state <= state_next;
      if (q_pop) cur <= q_dout;
      if (launch)                                k <= '0;
      else if (state == ST_GAP && k != LAST_K)   k <= k + 1'b1;
      // Requests arriving at any time merge into a single pending run.
      if (run_req)     run_pending <= 1'b1;
      else if (launch) run_pending <= 1'b0;
    end
  end
endmodule

// File: tb/tb_graph_controller.sv
// tb_graph_controller: directed self-checking bench for graph_controller.
// Engines are modelled as counters that raise done 11 cycles after their
// start pulse, giving a 13-cycle start-to-start spacing per phase.
module tb_graph_controller;
  import graph_pkg::*;

  localparam int NP = 3;

  logic            clk = 1'b0;
  logic            graph_reset;
  logic            run_req;
  logic            busy, run_done, err_timeout;
  logic [NP-1:0]   ph_start, ph_done, ph_vwe_b;
  logic [NP*6-1:0] ph_vaddr_a, ph_vaddr_b, ph_arow, ph_acol;
  logic [NP*32-1:0] ph_vdata_b;
  logic [5:0]      vm_addr_a, vm_addr_b, am_row, am_col;
  logic [31:0]     vm_data_b, am_data;
  logic            vm_we_b, am_we;

  graph_controller_if #(.VERT_W(6), .WEIGHT_W(32)) upd_if ();

  graph_controller #(
    .VERT_W(6), .WEIGHT_W(32), .DIST_W(32), .NUM_PHASES(NP),
    .FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .graph_reset(graph_reset), .upd(upd_if.slave), .run_req(run_req),
    .busy(busy), .run_done(run_done), .err_timeout(err_timeout),
    .ph_start(ph_start), .ph_done(ph_done),
    .ph_vaddr_a(ph_vaddr_a), .ph_vaddr_b(ph_vaddr_b), .ph_arow(ph_arow), .ph_acol(ph_acol),
    .ph_vdata_b(ph_vdata_b), .ph_vwe_b(ph_vwe_b),
    .vm_addr_a(vm_addr_a), .vm_addr_b(vm_addr_b), .vm_data_b(vm_data_b), .vm_we_b(vm_we_b),
    .am_row(am_row), .am_col(am_col), .am_data(am_data), .am_we(am_we)
  );

  always #5 clk = ~clk;

  // Engine models
  logic [NP-1:0] eng_act;
  int            eng_cnt [NP];
  logic          eng_mute = 1'b0;
  logic          done_force = 1'b0;

  for (genvar i = 0; i < NP; i++) begin : g_eng
    assign ph_done[i]             = (eng_act[i] && eng_cnt[i] == 0 && !eng_mute) || (i == 0 && done_force);
    assign ph_vaddr_a[i*6 +: 6]   = 6'(i + 1);
    assign ph_vaddr_b[i*6 +: 6]   = 6'(i + 8);
    assign ph_arow[i*6 +: 6]      = 6'(i + 16);
    assign ph_acol[i*6 +: 6]      = 6'(i + 24);
    assign ph_vdata_b[i*32 +: 32] = 32'(256 + i);
    assign ph_vwe_b[i]            = 1'b1;
  end

  always @(posedge clk or posedge graph_reset) begin
    if (graph_reset) begin
      eng_act <= '0;
      for (int i = 0; i < NP; i++) eng_cnt[i] <= 0;
    end else begin
      for (int i = 0; i < NP; i++) begin
        if (ph_start[i]) begin
          eng_act[i] <= 1'b1;
          eng_cnt[i] <= 10;
        end else if (eng_act[i] && eng_cnt[i] != 0) begin
          eng_cnt[i] <= eng_cnt[i] - 1;
        end else if (eng_act[i] && !eng_mute) begin
          eng_act[i] <= 1'b0;
        end
      end
    end
  end

  // Event monitor, sampled mid-cycle
  typedef struct { logic [5:0] row; logic [5:0] col; logic [31:0] data; int c; } wr_t;
  int   cyc = 0;
  wr_t  wr_q [$];
  int   st_cyc [$];
  logic [NP-1:0] st_val [$];
  int   done_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (am_we) wr_q.push_back('{am_row, am_col, am_data, cyc});
    if (ph_start != '0) begin
      st_cyc.push_back(cyc);
      st_val.push_back(ph_start);
    end
    if (run_done) done_q.push_back(cyc);
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one cycle; drop valid once the offered update has been taken.
  task automatic tick();
    logic acc;
    acc = upd_if.valid && upd_if.ready;
    @(posedge clk);
    #1;
    if (acc) upd_if.valid = 1'b0;
  endtask

  task automatic offer(input upd_t u);
    upd_if.src    = u.src;
    upd_if.dst    = u.dst;
    upd_if.weight = u.weight;
    upd_if.valid  = 1'b1;
  endtask

  upd_t vec [5];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    int budget;
    logic [31:0] neg;
    vec[0] = '{6'd1,  6'd2,  32'd10};
    vec[1] = '{6'd3,  6'd4,  32'hFFFF_FFEC};
    vec[2] = '{6'd6,  6'd7,  32'd30};
    vec[3] = '{6'd8,  6'd9,  32'd40};
    vec[4] = '{6'd10, 6'd11, 32'd50};

    graph_reset   = 1'b1;
    run_req       = 1'b0;
    upd_if.valid  = 1'b0;
    upd_if.src    = '0;
    upd_if.dst    = '0;
    upd_if.weight = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready",    upd_if.ready, 1);
    check("rst_busy",     busy, 0);
    check("rst_run_done", run_done, 0);
    check("rst_err",      err_timeout, 0);
    check("rst_ph_start", ph_start, 0);
    check("rst_am_we",    am_we, 0);
    check("rst_vm_we",    vm_we_b, 0);
    check("rst_am_data",  am_data, 0);
    check("rst_vm_addr",  vm_addr_a, 0);
    graph_reset = 1'b0;
    tick();

    // Forward + reverse write
    offer('{6'd2, 6'd5, 32'd100});
    tick();
    check("upd_busy_queued", busy, 1);
    check("upd_no_write_yet", am_we, 0);
    tick();
    check("fwd_we", am_we, 1);
    check("fwd_row", am_row, 2);
    check("fwd_col", am_col, 5);
    check("fwd_data", am_data, 100);
    tick();
    check("rev_we", am_we, 1);
    check("rev_row", am_row, 5);
    check("rev_col", am_col, 2);
    check("rev_data", am_data, 32'hFFFF_FF9C);
    tick();
    check("upd_end_we", am_we, 0);
    check("upd_end_busy", busy, 0);

    // Self-loop: one write only
    offer('{6'd3, 6'd3, 32'd7});
    tick();
    tick();
    check("self_we", am_we, 1);
    check("self_row", am_row, 3);
    check("self_col", am_col, 3);
    check("self_data", am_data, 7);
    tick();
    check("self_no_rev", am_we, 0);
    check("self_busy", busy, 0);

    // Most negative weight negates to itself
    offer('{6'd1, 6'd4, 32'h8000_0000});
    tick();
    tick();
    check("min_fwd", am_data, 32'h8000_0000);
    tick();
    check("min_rev_row", am_row, 4);
    check("min_rev", am_data, 32'h8000_0000);
    tick();

    // Full run with updates queued during phase 0
    wr_q.delete();
    st_cyc.delete();
    st_val.delete();
    done_q.delete();
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    tick();
    check("launch_ph_start", ph_start, 3'b001);
    check("launch_busy", busy, 1);
    tick();
    check("run0_vaddr_a", vm_addr_a, 1);
    check("run0_vaddr_b", vm_addr_b, 8);
    check("run0_vdata_b", vm_data_b, 256);
    check("run0_vwe_b", vm_we_b, 1);
    check("run0_arow", am_row, 16);
    check("run0_acol", am_col, 24);
    check("run0_am_we", am_we, 0);
    for (int i = 0; i < 4; i++) begin
      offer(vec[i]);
      tick();
    end
    offer(vec[4]);
    check("full_ready_low", upd_if.ready, 0);
    tick();
    check("full_ready_held", upd_if.ready, 0);
    check("full_valid_held", upd_if.valid, 1);
    budget = 0;
    while (done_q.size() == 0 && budget < 100) begin
      tick();
      budget++;
    end
    check("run_done_seen", done_q.size(), 1);
    budget = 0;
    while ((wr_q.size() < 10 || busy) && budget < 100) begin
      tick();
      budget++;
    end
    check("start_count", st_val.size(), 3);
    if (st_val.size() == 3 && done_q.size() == 1) begin
      check("start0", st_val[0], 3'b001);
      check("start1", st_val[1], 3'b010);
      check("start2", st_val[2], 3'b100);
      check("spacing01", st_cyc[1] - st_cyc[0], 13);
      check("spacing12", st_cyc[2] - st_cyc[1], 13);
      check("done_after_last", done_q[0] - st_cyc[2], 13);
    end
    check("write_count", wr_q.size(), 10);
    if (wr_q.size() == 10 && done_q.size() == 1) begin
      check("first_write_after_fin", wr_q[0].c - done_q[0], 2);
      for (int i = 0; i < 5; i++) begin
        neg = 32'd0 - vec[i].weight;
        check($sformatf("q%0d_fwd_row", i), wr_q[2*i].row,    vec[i].src);
        check($sformatf("q%0d_fwd_col", i), wr_q[2*i].col,    vec[i].dst);
        check($sformatf("q%0d_fwd_dat", i), wr_q[2*i].data,   vec[i].weight);
        check($sformatf("q%0d_rev_row", i), wr_q[2*i+1].row,  vec[i].dst);
        check($sformatf("q%0d_rev_col", i), wr_q[2*i+1].col,  vec[i].src);
        check($sformatf("q%0d_rev_dat", i), wr_q[2*i+1].data, neg);
      end
    end
    check("run_end_busy", busy, 0);
    check("run_end_err", err_timeout, 0);

`ifdef GRAPH_CTRL_WATCHDOG_EN
    // Phase 0 never finishes: watchdog aborts after 16 RUN cycles
    done_q.delete();
    eng_mute = 1'b1;
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    tick();
    check("wd_launch", ph_start, 3'b001);
    repeat (16) tick();
    check("wd_last_run_err", err_timeout, 0);
    check("wd_last_run_busy", busy, 1);
    tick();
    check("wd_err_set", err_timeout, 1);
    check("wd_idle", busy, 0);
    repeat (3) tick();
    check("wd_no_run_done", done_q.size(), 0);
    check("wd_err_sticky", err_timeout, 1);
    eng_mute = 1'b0;
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    check("wd_err_until_launch", err_timeout, 1);
    tick();
    check("wd_err_cleared", err_timeout, 0);
    tick();
    check("wd_stale_done_ignored", vm_we_b, 1);
    budget = 0;
    while (done_q.size() == 0 && budget < 100) begin
      tick();
      budget++;
    end
    check("wd_rerun_done", done_q.size(), 1);
    tick();
`else
    check("no_wd_err", err_timeout, 0);
`endif

    // done during LAUNCH is ignored, then reset mid-run
    done_force = 1'b1;
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    tick();
    check("force_launch", ph_start, 3'b001);
    done_force = 1'b0;
    tick();
    check("launch_done_ignored", vm_we_b, 1);
    tick();
    check("still_running", vm_we_b, 1);
    graph_reset = 1'b1;
    #1;
    check("midrst_ph_start", ph_start, 0);
    check("midrst_busy", busy, 0);
    check("midrst_vm_we", vm_we_b, 0);
    check("midrst_am_row", am_row, 0);
    check("midrst_ready", upd_if.ready, 1);
    tick();
    graph_reset = 1'b0;
    st_val.delete();
    st_cyc.delete();
    repeat (3) tick();
    check("midrst_stays_idle", busy, 0);
    check("midrst_no_restart", st_val.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
